pc_sequencer: RTL and testbench

- Owns the program counter and drives it to the branch adder (PC_Curr out), then consumes the adder's result (PC_New in) to choose the next PC.
- Sequences fetch → issue → retire per instruction with a req/ack handshake to instruction memory and a done strobe from the execute stage.
- Sits between instruction memory, the branch adder and the core's execute stage.
- Halts on request and reports completion to the top-level bench.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Holds the sequencer state encoding, the next-PC select encoding and
// the default widths / start address used by pc_sequencer and pc_next_sel.
package pc_seq_pkg;

  localparam int          PC_W_DEF       = 8;
  localparam int          INSTR_W_DEF    = 9;
  localparam logic [7:0]  START_ADDR_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD   = 2'd0,
    PC_SEL_INC    = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_START  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: hold, increment (wraps modulo 2^PC_W),
// branch target as-is, or the start address.
// Ports: sel_i (pc_sel_e), pc_curr_i, pc_new_i -> pc_next_o.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF)
) (
  input  pc_sel_e         sel_i,
  input  logic [PC_W-1:0] pc_curr_i,
  input  logic [PC_W-1:0] pc_new_i,
  output logic [PC_W-1:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_curr_i;
    case (sel_i)
      PC_SEL_HOLD:   pc_next_o = pc_curr_i;
      // Plain unsigned add; carry out is dropped so 'hFF wraps to 'h00.
      PC_SEL_INC:    pc_next_o = pc_curr_i + PC_W'(1);
      PC_SEL_BRANCH: pc_next_o = pc_new_i;
      PC_SEL_START:  pc_next_o = START_ADDR;
      default:       pc_next_o = pc_curr_i;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch -> issue -> retire per instruction,
// with req/ack to instruction memory and a done strobe from execute.
// Ports: CLK/RST_n, Start, PC_Curr/PC_New (branch adder), Fetch_Req/
// Fetch_Ack/Instr_In (imem), Instr_Out/Instr_Valid, Exec_Done/
// Branch_Taken/Halt_In (execute), Done (halted level).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              INSTR_W    = INSTR_W_DEF,
  parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF)
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               Start,
  output logic [PC_W-1:0]    PC_Curr,
  input  logic [PC_W-1:0]    PC_New,
  output logic               Fetch_Req,
  input  logic               Fetch_Ack,
  input  logic [INSTR_W-1:0] Instr_In,
  output logic [INSTR_W-1:0] Instr_Out,
  output logic               Instr_Valid,
  input  logic               Exec_Done,
  input  logic               Branch_Taken,
  input  logic               Halt_In,
  output logic               Done
);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  pc_sel_e            pc_sel;
  logic               instr_load;

  pc_next_sel #(
    .PC_W       (PC_W),
    .START_ADDR (START_ADDR)
  ) u_pc_next_sel (
    .sel_i     (pc_sel),
    .pc_curr_i (pc_q),
    .pc_new_i  (PC_New),
    .pc_next_o (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    pc_sel     = PC_SEL_HOLD;
    instr_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          pc_sel  = PC_SEL_START;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // PC is held while waiting, so the fetch address stays stable.
        if (Fetch_Ack) begin
          instr_load = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC: begin
        // Halt wins over branch; a halted PC keeps the retiring address.
        if (Exec_Done) begin
          if (Halt_In) begin
            state_d = ST_HALTED;
          end else begin
            pc_sel  = Branch_Taken ? PC_SEL_BRANCH : PC_SEL_INC;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_d = instr_load ? Instr_In : instr_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Strobes are pure state decodes: no input reaches an output combinationally.
  assign PC_Curr     = pc_q;
  assign Instr_Out   = instr_q;
  assign Fetch_Req   = (state_q == ST_FETCH);
  assign Instr_Valid = (state_q == ST_ISSUE);
  assign Done        = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       Start;
  logic [7:0] PC_Curr;
  logic [7:0] PC_New;
  logic       Fetch_Req;
  logic       Fetch_Ack;
  logic [8:0] Instr_In;
  logic [8:0] Instr_Out;
  logic       Instr_Valid;
  logic       Exec_Done;
  logic       Branch_Taken;
  logic       Halt_In;
  logic       Done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_pc_q[$];
  logic [8:0] exp_instr_q[$];
  logic [7:0] model_pc;

  pc_sequencer dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .Start        (Start),
    .PC_Curr      (PC_Curr),
    .PC_New       (PC_New),
    .Fetch_Req    (Fetch_Req),
    .Fetch_Ack    (Fetch_Ack),
    .Instr_In     (Instr_In),
    .Instr_Out    (Instr_Out),
    .Instr_Valid  (Instr_Valid),
    .Exec_Done    (Exec_Done),
    .Branch_Taken (Branch_Taken),
    .Halt_In      (Halt_In),
    .Done         (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expects the DUT to be in (or about to enter) FETCH; pops the expected
  // fetch address, holds off the ack, then checks issue of the word.
  task automatic do_fetch(input int ack_delay, input logic [8:0] instr);
    int n;
    logic [7:0] exp_pc;
    logic [8:0] exp_instr;
    n = 0;
    while (!Fetch_Req && n < 20) begin
      tick();
      n++;
    end
    check("fetch_req_seen", 32'(Fetch_Req), 32'(1'b1));
    if (exp_pc_q.size() == 0) begin
      check("exp_pc_queue_nonempty", 32'(0), 32'(1));
      exp_pc = 8'h00;
    end else begin
      exp_pc = exp_pc_q.pop_front();
    end
    check("fetch_pc", 32'(PC_Curr), 32'(exp_pc));
    for (int i = 0; i < ack_delay; i++) begin
      Instr_In = 9'($urandom);
      tick();
      check("fetch_req_held", 32'(Fetch_Req), 32'(1'b1));
      check("fetch_pc_stable", 32'(PC_Curr), 32'(exp_pc));
    end
    Fetch_Ack = 1'b1;
    Instr_In  = instr;
    exp_instr_q.push_back(instr);
    tick();
    Fetch_Ack = 1'b0;
    Instr_In  = 9'($urandom);
    exp_instr = exp_instr_q.pop_front();
    check("issue_valid", 32'(Instr_Valid), 32'(1'b1));
    check("issue_no_req", 32'(Fetch_Req), 32'(1'b0));
    check("issue_instr", 32'(Instr_Out), 32'(exp_instr));
    tick();
    check("valid_one_cycle", 32'(Instr_Valid), 32'(1'b0));
  endtask

  // Called in EXEC. Stray Start/Fetch_Ack and garbage branch/halt bits are
  // driven while Exec_Done is low; none of them may have any effect.
  task automatic do_exec(input int dly, input logic br, input logic hl, input logic [7:0] pnew);
    logic [8:0] held_instr;
    held_instr = Instr_Out;
    for (int i = 0; i < dly; i++) begin
      Exec_Done    = 1'b0;
      Branch_Taken = 1'($urandom);
      Halt_In      = 1'($urandom);
      PC_New       = 8'($urandom);
      Start        = 1'b1;
      Fetch_Ack    = 1'b1;
      Instr_In     = 9'($urandom);
      tick();
      check("exec_wait_no_req", 32'(Fetch_Req), 32'(1'b0));
      check("exec_wait_no_done", 32'(Done), 32'(1'b0));
      check("exec_wait_instr_kept", 32'(Instr_Out), 32'(held_instr));
    end
    Start        = 1'b0;
    Fetch_Ack    = 1'b0;
    Exec_Done    = 1'b1;
    Branch_Taken = br;
    Halt_In      = hl;
    PC_New       = pnew;
    if (!hl) begin
      model_pc = br ? pnew : model_pc + 8'h01;
      exp_pc_q.push_back(model_pc);
    end
    tick();
    Exec_Done    = 1'b0;
    Branch_Taken = 1'b0;
    Halt_In      = 1'b0;
    if (hl) begin
      check("halt_done", 32'(Done), 32'(1'b1));
      check("halt_pc", 32'(PC_Curr), 32'(model_pc));
      check("halt_no_req", 32'(Fetch_Req), 32'(1'b0));
    end else begin
      check("refetch_immediate", 32'(Fetch_Req), 32'(1'b1));
    end
  endtask

  initial begin
    RST_n = 1'b0; Start = 1'b0; PC_New = 8'h00; Fetch_Ack = 1'b0;
    Instr_In = 9'h000; Exec_Done = 1'b0; Branch_Taken = 1'b0; Halt_In = 1'b0;
    model_pc = 8'h00;
    #12;
    check("rst_pc", 32'(PC_Curr), 32'(8'h00));
    check("rst_req", 32'(Fetch_Req), 32'(1'b0));
    check("rst_valid", 32'(Instr_Valid), 32'(1'b0));
    check("rst_done", 32'(Done), 32'(1'b0));
    check("rst_instr", 32'(Instr_Out), 32'(9'h000));
    tick();
    RST_n = 1'b1;
    tick();
    tick();
    check("idle_no_req", 32'(Fetch_Req), 32'(1'b0));

    Start = 1'b1;
    exp_pc_q.push_back(8'h00);
    tick();
    Start = 1'b0;
    check("start_to_req", 32'(Fetch_Req), 32'(1'b1));

    do_fetch(3, 9'h1A5); do_exec(0, 1'b0, 1'b0, 8'h00);  // 00 -> 01
    do_fetch(0, 9'h033); do_exec(2, 1'b0, 1'b0, 8'h00);  // 01 -> 02
    do_fetch(1, 9'h0F0); do_exec(0, 1'b1, 1'b0, 8'h10);  // 02 -> 10
    do_fetch(0, 9'h111); do_exec(1, 1'b1, 1'b0, 8'h20);  // 10 -> 20
    do_fetch(0, 9'h122); do_exec(0, 1'b1, 1'b0, 8'h20);  // branch to self
    do_fetch(2, 9'h1FF); do_exec(0, 1'b1, 1'b0, 8'hFF);  // 20 -> FF
    do_fetch(0, 9'h0AA); do_exec(0, 1'b0, 1'b0, 8'h00);  // FF wraps to 00
    do_fetch(0, 9'h155); do_exec(0, 1'b1, 1'b0, 8'h37);  // 00 -> 37
    do_fetch(1, 9'h077); do_exec(1, 1'b1, 1'b1, 8'h99);  // halt beats branch

    tick();
    tick();
    check("halt_done_held", 32'(Done), 32'(1'b1));
    check("halt_pc_held", 32'(PC_Curr), 32'(8'h37));

    Start = 1'b1;
    model_pc = 8'h00;
    exp_pc_q.push_back(8'h00);
    tick();
    Start = 1'b0;
    check("restart_done_drop", 32'(Done), 32'(1'b0));
    do_fetch(0, 9'h0C3); do_exec(0, 1'b1, 1'b0, 8'h42);
    do_fetch(0, 9'h13C);

    // Now in EXEC at PC 42: async reset must act before any clock edge.
    #3;
    RST_n = 1'b0;
    #1;
    check("async_rst_pc", 32'(PC_Curr), 32'(8'h00));
    check("async_rst_req", 32'(Fetch_Req), 32'(1'b0));
    check("async_rst_done", 32'(Done), 32'(1'b0));
    check("async_rst_instr", 32'(Instr_Out), 32'(9'h000));
    check("exp_pc_queue_drained", 32'(exp_pc_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
